// File: rtl/vga_pkg.sv
// Default 640x480@60 raster constants shared by the timing generator and the layer engines.
package vga_pkg;
    localparam int COORD_W    = 10;
    localparam int TILE_SHIFT = 5;

    localparam int DIV_DEFAULT        = 4;
    localparam int SYNC_DELAY_DEFAULT = 1;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    function automatic logic in_window(input int val, input int lo, input int hi);
        return (val >= lo) && (val < hi);
    endfunction
endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register that realigns sync outputs with the registered colour path.
module sync_delay_line
    import vga_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stages [DEPTH];

            // Syncs are active-low, so idle (all-ones) is the safe reset value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= '1;
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider plus horizontal/vertical raster counters with registered decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int DIV        = vga_pkg::DIV_DEFAULT,
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int SYNC_DELAY = vga_pkg::SYNC_DELAY_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pixel_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);
    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START    = H_ACTIVE + H_FP;
    localparam int HS_END      = HS_START + H_SYNC;
    localparam int VS_START    = V_ACTIVE + V_FP;
    localparam int VS_END      = VS_START + V_SYNC;
    localparam int DIV_W       = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic               tick_en;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic               wrap;
    logic               hs_raw;
    logic               vs_raw;

    assign tick_en = (div_cnt == DIV_W'(DIV - 1));

    always_comb begin
        x_nxt = x;
        y_nxt = y;
        wrap  = 1'b0;
        if (tick_en) begin
            if (x == COORD_W'(LINE_LEN - 1)) begin
                x_nxt = '0;
                if (y == COORD_W'(FRAME_LINES - 1)) begin
                    y_nxt = '0;
                    wrap  = 1'b1;
                end else begin
                    y_nxt = y + 1'b1;
                end
            end else begin
                x_nxt = x + 1'b1;
            end
        end
    end

    // Decode from the next counter values so the flags land on the same edge as x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            pixel_tick  <= 1'b0;
            x           <= '0;
            y           <= '0;
            video_on    <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= tick_en ? '0 : div_cnt + 1'b1;
            pixel_tick  <= tick_en;
            x           <= x_nxt;
            y           <= y_nxt;
            frame_start <= wrap;
            if (tick_en) begin
                video_on <= (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
                hs_raw   <= !in_window(int'(x_nxt), HS_START, HS_END);
                vs_raw   <= !in_window(int'(y_nxt), VS_START, VS_END);
            end
        end
    end

    sync_delay_line #(
        .DEPTH (SYNC_DELAY),
        .WIDTH (2)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({hs_raw, vs_raw}),
        .dout  ({hsync, vsync})
    );
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size line timing plus two shrunken rasters for frame/sync-delay cases.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       tick;
        logic       von;
        logic       hs;
        logic       vs;
        logic       fs;
    } vout_t;

    typedef struct packed {
        int ha; int hfp; int hsw; int hbp;
        int va; int vfp; int vsw; int vbp;
        int d;
    } cfg_t;

    typedef struct {
        int    k;
        vout_t e;
    } vec_t;

    localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    localparam cfg_t CFG_B = '{16, 2, 4, 3, 6, 2, 2, 3, 3};
    localparam cfg_t CFG_C = '{16, 2, 4, 3, 6, 2, 2, 3, 0};
    localparam vout_t RST_EXP = '{10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic clk;
    logic rst_n;
    int   k;
    int   errors;
    int   checks;
    logic rnd_en;
    logic mon_en;

    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic tick_a, von_a, hs_a, vs_a, fs_a;
    logic tick_b, von_b, hs_b, vs_b, fs_b;
    logic tick_c, von_c, hs_c, vs_c, fs_c;
    vout_t obs_a, obs_b, obs_c;

    assign obs_a = {x_a, y_a, tick_a, von_a, hs_a, vs_a, fs_a};
    assign obs_b = {x_b, y_b, tick_b, von_b, hs_b, vs_b, fs_b};
    assign obs_c = {x_c, y_c, tick_c, von_c, hs_c, vs_c, fs_c};

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_n), .pixel_tick(tick_a), .x(x_a), .y(y_a),
        .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(3)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .pixel_tick(tick_b), .x(x_b), .y(y_b),
        .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(0)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .pixel_tick(tick_c), .x(x_c), .y(y_c),
        .video_on(von_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // k = number of clk edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Reference: after k edges the raster has advanced floor(k/4) pixels from (0,0).
    function automatic vout_t model(input int kk, input cfg_t c);
        vout_t r;
        int ht, vt, upd, pos, px, py, j, jp, jx, jy;
        ht  = c.ha + c.hfp + c.hsw + c.hbp;
        vt  = c.va + c.vfp + c.vsw + c.vbp;
        upd = kk / 4;
        pos = upd % (ht * vt);
        px  = pos % ht;
        py  = pos / ht;
        r.x    = 10'(px);
        r.y    = 10'(py);
        r.tick = (kk > 0) && (kk % 4 == 0);
        r.fs   = (upd > 0) && (kk % 4 == 0) && (pos == 0);
        r.von  = (upd > 0) && (px < c.ha) && (py < c.va);
        j = kk - c.d;
        if (j < 0) begin
            r.hs = 1'b1;
            r.vs = 1'b1;
        end else begin
            jp = (j / 4) % (ht * vt);
            jx = jp % ht;
            jy = jp / ht;
            r.hs = !((jx >= c.ha + c.hfp) && (jx < c.ha + c.hfp + c.hsw));
            r.vs = !((jy >= c.va + c.vfp) && (jy < c.va + c.vfp + c.vsw));
        end
        return r;
    endfunction

    task automatic check(input string name, input vout_t got, input vout_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got x=%0d y=%0d tick=%b von=%b hs=%b vs=%b fs=%b required x=%0d y=%0d tick=%b von=%b hs=%b vs=%b fs=%b",
                     name, k, got.x, got.y, got.tick, got.von, got.hs, got.vs, got.fs,
                     exp.x, exp.y, exp.tick, exp.von, exp.hs, exp.vs, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s k=%0d got %0d required %0d", name, k, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at k=%0d", name, k);
    endtask

    function automatic vec_t mk(input int kk, input int xx, input int yy,
                                input logic t, input logic v, input logic h);
        vec_t r;
        r.k = kk;
        r.e = '{10'(xx), 10'(yy), t, v, h, 1'b1, 1'b0};
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rnd_en && ($urandom_range(0, 7) == 0)) begin
            check("model_a", obs_a, model(k, CFG_A));
            check("model_b", obs_b, model(k, CFG_B));
            check("model_c", obs_c, model(k, CFG_C));
        end
    end

    int   hs_low_a, hs_falls_a, vs_low_c, fs_cnt_b, last_fs;
    logic prev_hs_a;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (!hs_a) hs_low_a++;
            if (prev_hs_a && !hs_a) begin
                hs_falls_a++;
                check_int("hsync_fall_x", int'(x_a), 656);
            end
            if (k <= 1300 && !vs_c) vs_low_c++;
            if (fs_b) fs_cnt_b++;
        end
        prev_hs_a = hs_a;
        if (!rst_n) begin
            last_fs = -1;
        end else if (fs_b) begin
            check_int("fs_at_origin", int'(x_b) + int'(y_b), 0);
            if (last_fs >= 0) check_int("fs_period", k - last_fs, 1300);
            last_fs = k;
        end
    end

    vec_t vecs[$];
    int   kc, kb, n_wait;
    logic pc, pb, found;

    initial begin
        errors = 0; checks = 0;
        hs_low_a = 0; hs_falls_a = 0; vs_low_c = 0; fs_cnt_b = 0; last_fs = -1;
        prev_hs_a = 1'b1;
        rnd_en = 1'b0; mon_en = 1'b0;
        rst_n = 1'b0;

        vecs.push_back(mk(1,    0,   0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(3,    0,   0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(4,    1,   0, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mk(5,    1,   0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(7,    1,   0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(8,    2,   0, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mk(2556, 639, 0, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mk(2559, 639, 0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(2560, 640, 0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(2624, 656, 0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(2625, 656, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3007, 751, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3008, 752, 0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(3009, 752, 0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(3196, 799, 0, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(3200, 0,   1, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mk(3201, 0,   1, 1'b0, 1'b1, 1'b1));

        repeat (3) @(negedge clk);
        check("reset_a", obs_a, RST_EXP);
        check("reset_b", obs_b, RST_EXP);
        check("reset_c", obs_c, RST_EXP);

        rst_n = 1'b1;
        rnd_en = 1'b1;
        mon_en = 1'b1;
        foreach (vecs[i]) begin
            while (k < vecs[i].k) @(negedge clk);
            check($sformatf("vec%0d_k%0d", i, vecs[i].k), obs_a, vecs[i].e);
        end
        mon_en = 1'b0;
        check_int("hsync_low_clks", hs_low_a, 384);
        check_int("hsync_falls", hs_falls_a, 1);
        check_int("vsync_low_clks", vs_low_c, 200);
        check_int("frame_starts", fs_cnt_b, 2);

        // sync-delay lag between SYNC_DELAY=3 and SYNC_DELAY=0 copies
        kc = -1; kb = -1; pc = hs_c; pb = hs_b;
        for (int n = 0; n < 400 && (kc < 0 || kb < 0); n++) begin
            @(negedge clk);
            if (pc && !hs_c && kc < 0) begin
                kc = k;
                check_int("hs0_fall_x", int'(x_c), 18);
            end
            if (pb && !hs_b && kb < 0 && kc >= 0) kb = k;
            pc = hs_c;
            pb = hs_b;
        end
        if (kc < 0 || kb < 0) fail_timeout("hs_lag");
        else check_int("hs_lag", kb - kc, 3);

        // mid-frame asynchronous reset
        found = 1'b0;
        for (int n = 0; n < 1400 && !found; n++) begin
            @(negedge clk);
            if (x_b == 10'd10 && y_b == 10'd3) found = 1'b1;
        end
        if (!found) fail_timeout("reach_mid_frame");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", obs_a, RST_EXP);
        check("async_reset_b", obs_b, RST_EXP);
        check("async_reset_c", obs_c, RST_EXP);
        repeat (2) @(negedge clk);
        check("held_reset_b", obs_b, RST_EXP);
        rst_n = 1'b1;
        found = 1'b0;
        n_wait = 0;
        while (!found && n_wait < 1400) begin
            @(negedge clk);
            n_wait++;
            if (fs_b) found = 1'b1;
        end
        if (!found) fail_timeout("fs_after_reset");
        else check_int("fs_after_reset_k", k, 1300);

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(100, 1500)) @(negedge clk);
            #2 rst_n = 1'b0;
            #1 check($sformatf("rand_reset%0d_a", r), obs_a, RST_EXP);
            check($sformatf("rand_reset%0d_b", r), obs_b, RST_EXP);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (1500) @(negedge clk);
        rnd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream raster source for the tank-game display pipeline.
- Derives a 25 MHz pixel enable from the 100 MHz system clock and runs horizontal/vertical counters for 640x480@60.
- Drives x, y and video_on into background_engine and the sprite/tank layers.
- Emits VGA hsync/vsync delayed by a fixed number of clk cycles, so they stay aligned with the registered colour the layer engines produce.
- Also produces a frame_start pulse for game-logic updates.

Parameters:
- DIV, 4: clk cycles per pixel; 100 MHz / 4 = 25 MHz.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: hsync pulse width.
- H_BP, 48: horizontal back porch. H_TOTAL = 800.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vsync pulse width.
- V_BP, 33: vertical back porch. V_TOTAL = 525.
- SYNC_DELAY, 1: clk-cycle delay applied to hsync/vsync outputs, matching downstream pixel latency. Legal range 0..7.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- pixel_tick, output, 1: one-clk pulse, once every DIV cycles.
- x, output, 10: horizontal counter, 0..H_TOTAL-1.
- y, output, 10: vertical counter, 0..V_TOTAL-1.
- video_on, output, 1: high when x < H_ACTIVE and y < V_ACTIVE.
- hsync, output, 1: active-low horizontal sync, delayed SYNC_DELAY clks.
- vsync, output, 1: active-low vertical sync, delayed SYNC_DELAY clks.
- frame_start, output, 1: one-clk pulse when counters wrap to (0,0).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - divider=0, x=0, y=0.
  - pixel_tick=0, video_on=0, frame_start=0.
  - hsync=1, vsync=1, and every delay-line stage =1.
- Divider:
  - Counts 0..DIV-1, wrapping to 0.
  - pixel_tick is registered and high for exactly the clk cycle after divider==DIV-1.
  - First pixel_tick occurs DIV clks after reset release.
- Counter advance, on each clk edge where divider==DIV-1:
  - x increments. If x==H_TOTAL-1, x wraps to 0 and y increments.
  - If y==V_TOTAL-1 at the same time, y wraps to 0.
  - x and y are held constant for the DIV clks between ticks.
- Decode (all outputs registered, updated on the same edge as x/y and decoded from the next counter values, so they are consistent with x/y every cycle):
  - video_on: as defined above.
  - raw hsync low for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - raw vsync low for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - video_on stays 0 after reset until the first counter update. Thereafter it follows the decode.
- frame_start:
  - Asserted for one clk on the edge where (x,y) wraps from (799,524) to (0,0).
  - Never asserted for the reset-induced (0,0).
- Sync delay:
  - Raw hsync/vsync pass through a SYNC_DELAY-stage shift register clocked every clk, not on pixel_tick.
  - SYNC_DELAY=0 makes hsync/vsync equal to the raw registered decode.
- Reset mid-frame: all state returns to reset values immediately. Timing restarts from (0,0) with no partial frame_start.
- Widths: 10-bit counters are sufficient (max 799). Compare against widened parameter sums to avoid truncation.
- Frame period: H_TOTAL*V_TOTAL*DIV = 1,680,000 clks.

Decomposition:
- Package vga_pkg holds:
  - default timing constants (H_/V_ ACTIVE/FP/SYNC/BP).
  - derived H_TOTAL, V_TOTAL, H_SYNC_START/END, V_SYNC_START/END.
  - COORD_W=10.
  - TILE_SHIFT=5, shared with background_engine's 32-pixel tile map.
- One sub-module, sync_delay_line:
  - Parameterised depth and width=2.
  - Asynchronous reset to all-ones.
  - Pass-through when depth is 0.

Test Plan:
- Reset release, defaults:
  - First pixel_tick at clk 4.
  - x reaches 1 after first tick.
  - pixel_tick period exactly 4 clks; x stable between ticks.
- Line timing:
  - From x=0 to next x=0: 3200 clks.
  - Raw hsync low exactly 96 ticks, starting at x=656.
  - video_on drops when x goes 639->640 with y<480.
- Frame timing:
  - y=479->480 drops video_on for the whole line.
  - vsync low for y=490..491 only (1600 ticks).
  - frame_start pulses once, 1,680,000 clks apart, coincident with x=0,y=0.
- Sync delay:
  - SYNC_DELAY=3: hsync edge lags raw decode by exactly 3 clks.
  - SYNC_DELAY=0: zero lag.
  - During reset, both outputs read 1.
- Mid-frame reset:
  - Assert rst_n=0 at x=300,y=200.
  - Outputs go to reset values immediately (no clk edge needed).
  - After release, counting restarts at (0,0) and no frame_start occurs until the next full wrap.
- Integration with background_engine:
  - Drive its x/y/video_on from this block.
  - At x=100,y=100 (tile 3,3) the wall colour appears while video_on=1.
  - color is 0 whenever video_on=0.
